// File: rtl/pipe_stage_reg_pkg.sv
// Shared state encoding and default widths for the pipe_stage_reg pipeline slice.
// Define PIPE_STAGE_SKID_EN to build the two-entry skid variant.
package pipe_stage_reg_pkg;

   localparam int unsigned DEFAULT_DATA_W = 64;
   localparam int unsigned DEFAULT_CTRL_W = 10;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_BUSY  = 2'd1,
      ST_FULL  = 2'd2
   } stage_state_e;

   function automatic logic [1:0] state_occupancy(input stage_state_e st);
      case (st)
         ST_BUSY: return 2'd1;
         ST_FULL: return 2'd2;
         default: return 2'd0;
      endcase
   endfunction

endpackage

// File: rtl/pipe_entry_reg.sv
// Single storage entry: enabled register with async active-low reset and a
// synchronous clear that wins over the load enable.
module pipe_entry_reg #(
   parameter int unsigned W = 8
) (
   input  logic         clk,
   input  logic         rst_ni,
   input  logic         clr_i,
   input  logic         en_i,
   input  logic [W-1:0] d_i,
   output logic [W-1:0] q_o
);

   logic [W-1:0] q_q;
   logic [W-1:0] q_d;

   always_comb begin
      q_d = q_q;
      if (clr_i) begin
         q_d = '0;
      end else if (en_i) begin
         q_d = d_i;
      end
   end

   always_ff @(posedge clk or negedge rst_ni) begin
      if (!rst_ni) begin
         q_q <= '0;
      end else begin
         q_q <= q_d;
      end
   end

   assign q_o = q_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Valid/ready pipeline stage register with flush. PIPE_STAGE_SKID_EN selects the
// two-entry skid version with a registered in_ready; otherwise a single entry.
module pipe_stage_reg
   import pipe_stage_reg_pkg::*;
#(
   parameter int unsigned DATA_W = DEFAULT_DATA_W,
   parameter int unsigned CTRL_W = DEFAULT_CTRL_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [CTRL_W-1:0] in_ctrl,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [CTRL_W-1:0] out_ctrl,
   output logic [DATA_W-1:0] out_data,
   output logic [1:0]        occupancy
);

   stage_state_e state_q;
   stage_state_e state_d;

   logic              accept;
   logic              retire;
   logic              main_load;
   logic [CTRL_W-1:0] main_ctrl_in;
   logic [DATA_W-1:0] main_data_in;
   logic [CTRL_W-1:0] main_ctrl;

   assign out_valid = (state_q != ST_EMPTY);
   assign accept    = in_valid & in_ready;
   assign retire    = out_valid & out_ready;

`ifdef PIPE_STAGE_SKID_EN
   logic              skid_load;
   logic              main_from_skid;
   logic              in_ready_q;
   logic              in_ready_d;
   logic [CTRL_W-1:0] skid_ctrl;
   logic [DATA_W-1:0] skid_data;

   assign in_ready_d = (state_d != ST_FULL);
   assign in_ready   = in_ready_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         in_ready_q <= 1'b1;
      end else begin
         in_ready_q <= in_ready_d;
      end
   end

   assign main_ctrl_in = main_from_skid ? skid_ctrl : in_ctrl;
   assign main_data_in = main_from_skid ? skid_data : in_data;

   pipe_entry_reg #(.W(CTRL_W)) u_skid_ctrl (
      .clk(clk), .rst_ni(reset), .clr_i(flush), .en_i(skid_load),
      .d_i(in_ctrl), .q_o(skid_ctrl)
   );

   pipe_entry_reg #(.W(DATA_W)) u_skid_data (
      .clk(clk), .rst_ni(reset), .clr_i(1'b0), .en_i(skid_load),
      .d_i(in_data), .q_o(skid_data)
   );
`else
   // Single entry: downstream readiness passes straight through.
   assign in_ready     = out_ready | ~out_valid;
   assign main_ctrl_in = in_ctrl;
   assign main_data_in = in_data;
`endif

   always_comb begin
      state_d   = state_q;
      main_load = 1'b0;
`ifdef PIPE_STAGE_SKID_EN
      skid_load      = 1'b0;
      main_from_skid = 1'b0;
`endif
      case (state_q)
         ST_EMPTY: begin
            if (accept) begin
               state_d   = ST_BUSY;
               main_load = 1'b1;
            end
         end
         ST_BUSY: begin
            if (accept && retire) begin
               main_load = 1'b1;
            end else if (accept) begin
`ifdef PIPE_STAGE_SKID_EN
               state_d   = ST_FULL;
               skid_load = 1'b1;
`endif
            end else if (retire) begin
               state_d = ST_EMPTY;
            end
         end
`ifdef PIPE_STAGE_SKID_EN
         ST_FULL: begin
            if (retire) begin
               state_d        = ST_BUSY;
               main_load      = 1'b1;
               main_from_skid = 1'b1;
            end
         end
`endif
         default: state_d = ST_EMPTY;
      endcase
      // Flush kills everything, including this cycle's input; data payloads hold.
      if (flush) begin
         state_d   = ST_EMPTY;
         main_load = 1'b0;
`ifdef PIPE_STAGE_SKID_EN
         skid_load = 1'b0;
`endif
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= ST_EMPTY;
      end else begin
         state_q <= state_d;
      end
   end

   pipe_entry_reg #(.W(CTRL_W)) u_main_ctrl (
      .clk(clk), .rst_ni(reset), .clr_i(flush), .en_i(main_load),
      .d_i(main_ctrl_in), .q_o(main_ctrl)
   );

   pipe_entry_reg #(.W(DATA_W)) u_main_data (
      .clk(clk), .rst_ni(reset), .clr_i(1'b0), .en_i(main_load),
      .d_i(main_data_in), .q_o(out_data)
   );

   assign out_ctrl  = out_valid ? main_ctrl : '0;
   assign occupancy = state_occupancy(state_q);

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed self-checking bench for pipe_stage_reg; follows PIPE_STAGE_SKID_EN
// to pick the skid or single-entry expectations.
module tb_pipe_stage_reg;

   localparam int DATA_W = 64;
   localparam int CTRL_W = 10;

   logic              clk = 1'b0;
   logic              reset;
   logic              flush;
   logic              in_valid;
   logic              in_ready;
   logic [CTRL_W-1:0] in_ctrl;
   logic [DATA_W-1:0] in_data;
   logic              out_valid;
   logic              out_ready;
   logic [CTRL_W-1:0] out_ctrl;
   logic [DATA_W-1:0] out_data;
   logic [1:0]        occupancy;

   int checks   = 0;
   int failures = 0;

   pipe_stage_reg #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) dut (
      .clk(clk), .reset(reset), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl),
      .out_data(out_data), .occupancy(occupancy)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end else begin
         $display("ok   %s = 0x%0h", tag, got);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_ctrl = '0; in_data = '0; out_ready = 1'b0;
      #1 reset = 1'b0;
      #7;
      check_eq("rst_out_valid", 64'(out_valid), 64'd0);
      check_eq("rst_in_ready",  64'(in_ready),  64'd1);
      check_eq("rst_occupancy", 64'(occupancy), 64'd0);
      check_eq("rst_out_ctrl",  64'(out_ctrl),  64'd0);
      check_eq("rst_out_data",  out_data,       64'd0);
      #4 reset = 1'b1;

      // First accept: one cycle latency.
      in_valid = 1'b1; in_data = 64'h1234; in_ctrl = 10'h3FF; out_ready = 1'b1;
      step();
      check_eq("acc_out_valid", 64'(out_valid), 64'd1);
      check_eq("acc_out_data",  out_data,       64'h1234);
      check_eq("acc_out_ctrl",  64'(out_ctrl),  64'h3FF);
      check_eq("acc_occupancy", 64'(occupancy), 64'd1);

      // Retire only: bubble must present zero control.
      in_valid = 1'b0;
      step();
      check_eq("ret_out_valid", 64'(out_valid), 64'd0);
      check_eq("ret_out_ctrl",  64'(out_ctrl),  64'd0);
      check_eq("ret_occupancy", 64'(occupancy), 64'd0);

      // Streaming 0..15 with out_ready high: one output per cycle, in order.
      for (int i = 0; i < 16; i++) begin
         in_valid = 1'b1; in_data = 64'(i); in_ctrl = 10'(i + 1);
         step();
         check_eq($sformatf("stream%0d_valid", i), 64'(out_valid), 64'd1);
         check_eq($sformatf("stream%0d_data", i),  out_data,       64'(i));
         check_eq($sformatf("stream%0d_ctrl", i),  64'(out_ctrl),  64'(i + 1));
      end
      in_valid = 1'b0;
      step();
      check_eq("stream_drain_valid", 64'(out_valid), 64'd0);

`ifdef PIPE_STAGE_SKID_EN
      // Fill main and skid with downstream stalled.
      out_ready = 1'b0;
      in_valid = 1'b1; in_data = 64'hA; in_ctrl = 10'h00A;
      step();
      check_eq("skidA_occupancy", 64'(occupancy), 64'd1);
      check_eq("skidA_in_ready",  64'(in_ready),  64'd1);
      in_data = 64'hB; in_ctrl = 10'h00B;
      step();
      check_eq("skidB_occupancy", 64'(occupancy), 64'd2);
      check_eq("skidB_in_ready",  64'(in_ready),  64'd0);
      check_eq("skidB_out_data",  out_data,       64'hA);
      in_data = 64'hC;
      step();
      check_eq("full_hold_data",  out_data,       64'hA);
      check_eq("full_hold_occ",   64'(occupancy), 64'd2);
      in_valid = 1'b0; out_ready = 1'b1;
      step();
      check_eq("drainB_data",     out_data,       64'hB);
      check_eq("drainB_ctrl",     64'(out_ctrl),  64'h00B);
      check_eq("drainB_occ",      64'(occupancy), 64'd1);
      check_eq("drainB_in_ready", 64'(in_ready),  64'd1);
      step();
      check_eq("drain_empty",     64'(out_valid), 64'd0);

      // Flush while FULL with a live input.
      out_ready = 1'b0; in_valid = 1'b1; in_data = 64'h11; in_ctrl = 10'h011;
      step();
      in_data = 64'h22; in_ctrl = 10'h022;
      step();
      check_eq("prefl_occ", 64'(occupancy), 64'd2);
      flush = 1'b1; in_data = 64'h33; in_ctrl = 10'h033;
      step();
      check_eq("fl_out_valid", 64'(out_valid), 64'd0);
      check_eq("fl_out_ctrl",  64'(out_ctrl),  64'd0);
      check_eq("fl_occupancy", 64'(occupancy), 64'd0);
      check_eq("fl_in_ready",  64'(in_ready),  64'd1);
      check_eq("fl_data_hold", out_data,       64'h11);
      flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      step();
      check_eq("postfl_valid", 64'(out_valid), 64'd0);
`else
      // Combinational in_ready follows out_ready while an entry is held.
      in_valid = 1'b1; in_data = 64'h77; in_ctrl = 10'h077; out_ready = 1'b1;
      step();
      in_valid = 1'b0; out_ready = 1'b0;
      #1;
      check_eq("ready_stall", 64'(in_ready), 64'd0);
      out_ready = 1'b1;
      #1;
      check_eq("ready_go",    64'(in_ready), 64'd1);
      out_ready = 1'b0; in_valid = 1'b1; in_data = 64'h55; in_ctrl = 10'h055;
      step();
      check_eq("stall_hold_data", out_data,       64'h77);
      check_eq("stall_hold_occ",  64'(occupancy), 64'd1);
      out_ready = 1'b1;
      step();
      check_eq("unstall_data",    out_data,       64'h55);
      check_eq("unstall_ctrl",    64'(out_ctrl),  64'h055);

      // Flush while BUSY with a live input.
      flush = 1'b1; in_data = 64'h33; in_ctrl = 10'h033;
      step();
      check_eq("fl_out_valid", 64'(out_valid), 64'd0);
      check_eq("fl_out_ctrl",  64'(out_ctrl),  64'd0);
      check_eq("fl_occupancy", 64'(occupancy), 64'd0);
      check_eq("fl_data_hold", out_data,       64'h55);
      flush = 1'b0; in_valid = 1'b0;
      step();
      check_eq("postfl_valid", 64'(out_valid), 64'd0);
`endif

      // Asynchronous reset while BUSY.
      out_ready = 1'b0; in_valid = 1'b1; in_data = 64'h99; in_ctrl = 10'h199;
      step();
      check_eq("prerst_valid", 64'(out_valid), 64'd1);
      in_valid = 1'b0;
      #2 reset = 1'b0;
      #1;
      check_eq("arst_out_valid", 64'(out_valid), 64'd0);
      check_eq("arst_out_ctrl",  64'(out_ctrl),  64'd0);
      check_eq("arst_out_data",  out_data,       64'd0);
      check_eq("arst_in_ready",  64'(in_ready),  64'd1);
      #2 reset = 1'b1;
      in_valid = 1'b1; in_data = 64'h5A; in_ctrl = 10'h05A; out_ready = 1'b1;
      step();
      check_eq("postrst_valid", 64'(out_valid), 64'd1);
      check_eq("postrst_data",  out_data,       64'h5A);
      in_valid = 1'b0;
      step();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
